// File: rtl/as5600_i2c_pkg.sv
// Shared definitions for the AS5600 read-path I2C target: FSM states,
// register addresses and default bus identity.
package as5600_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic [7:0] REG_STATUS      = 8'h0B;
  localparam logic [7:0] REG_RAW_ANGLE_H = 8'h0C;
  localparam logic [7:0] REG_RAW_ANGLE_L = 8'h0D;
  localparam logic [7:0] REG_ANGLE_H     = 8'h0E;
  localparam logic [7:0] REG_ANGLE_L     = 8'h0F;

  localparam logic [6:0] AS5600_DEV_ADDR  = 7'h36;
  localparam logic [7:0] AS5600_RESET_PTR = 8'h0C;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad conditioning for an I2C bus: 2-flop synchronizer, FILT_LEN-sample
// glitch filter per line, and one-cycle edge / START / STOP strobes.
module i2c_bus_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic                scl_p0, scl_p1, sda_p0, sda_p1;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_q, sda_q;

  // Idle bus is high on both lines, so everything resets to 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_p0   <= 1'b1;
      scl_p1   <= 1'b1;
      sda_p0   <= 1'b1;
      sda_p1   <= 1'b1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_p0   <= scl_in;
      scl_p1   <= scl_p0;
      sda_p0   <= sda_in;
      sda_p1   <= sda_p0;
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_p1};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_p1};
      if (&scl_hist)       scl <= 1'b1;
      else if (~|scl_hist) scl <= 1'b0;
      if (&sda_hist)       sda <= 1'b1;
      else if (~|sda_hist) sda <= 1'b0;
      scl_q    <= scl;
      sda_q    <= sda;
    end
  end

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 read path: pointer writes, auto-incrementing
// reads of a coherent angle/status snapshot taken at the read address ACK.
module as5600_i2c_target
  import as5600_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = AS5600_DEV_ADDR,
  parameter logic [7:0] RESET_PTR = AS5600_RESET_PTR,
  parameter int         FILT_LEN  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] angle_in,
  input  logic [2:0]  magnet_status,
  output logic        busy,
  output logic        rd_pulse,
  output logic [7:0]  ptr
);

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.FILT_LEN(FILT_LEN)) u_bus_sync (
    .clock    (clock),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl      (scl_f),
    .sda      (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_t  state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  sh, sh_n, ptr_n, rx_byte, rd_byte;
  logic [11:0] snap, snap_n;
  logic [2:0]  stat, stat_n;
  logic        rw, rw_n, phase, phase_n, rd_sent, rd_sent_n;
  logic        sda_oe_n, busy_n, rd_pulse_n;

  function automatic logic [7:0] reg_read(input logic [7:0]  addr,
                                          input logic [11:0] ang,
                                          input logic [2:0]  st);
    case (addr)
      REG_STATUS:                   return {2'b00, st, 3'b000};
      REG_RAW_ANGLE_H, REG_ANGLE_H: return {4'h0, ang[11:8]};
      REG_RAW_ANGLE_L, REG_ANGLE_L: return ang[7:0];
      default:                      return 8'h00;
    endcase
  endfunction

  assign rx_byte = {sh[6:0], sda_f};
  assign rd_byte = reg_read(ptr, snap, stat);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      sh       <= 8'h00;
      rw       <= 1'b0;
      phase    <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rd_pulse <= 1'b0;
      rd_sent  <= 1'b0;
      ptr      <= RESET_PTR;
      snap     <= 12'h000;
      stat     <= 3'b000;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      sh       <= sh_n;
      rw       <= rw_n;
      phase    <= phase_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
      rd_pulse <= rd_pulse_n;
      rd_sent  <= rd_sent_n;
      ptr      <= ptr_n;
      snap     <= snap_n;
      stat     <= stat_n;
    end
  end

  // phase marks the second half of a 9th-bit slot (ACK driven / ACK sampled).
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    sh_n       = sh;
    rw_n       = rw;
    phase_n    = phase;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    rd_pulse_n = 1'b0;
    rd_sent_n  = rd_sent;
    ptr_n      = ptr;
    snap_n     = snap;
    stat_n     = stat;

    if (stop) begin
      state_n    = IDLE;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      rd_pulse_n = rd_sent;
      rd_sent_n  = 1'b0;
    end else if (start) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      rd_sent_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n      = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            phase_n = 1'b0;
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_n = ADDR_ACK;
              rw_n    = rx_byte[0];
              busy_n  = 1'b1;
              if (rx_byte[0]) begin
                snap_n = angle_in;
                stat_n = magnet_status;
              end
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        PTR: if (scl_rise) begin
          sh_n      = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_n   = rx_byte;
            phase_n = 1'b0;
            state_n = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          sh_n      = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            phase_n = 1'b0;
            state_n = WDATA_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_oe_n = 1'b1;
            phase_n  = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd0;
            if (state == ADDR_ACK && rw) begin
              state_n  = TX;
              sh_n     = rd_byte;
              sda_oe_n = ~rd_byte[7];
            end else if (state == WDATA_ACK) begin
              state_n = WDATA;
              ptr_n   = ptr + 8'd1;
            end else if (state == PTR_ACK) begin
              state_n = WDATA;
            end else begin
              state_n = PTR;
            end
          end
        end
        TX: if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd0;
            phase_n   = 1'b0;
            rd_sent_n = 1'b1;
            state_n   = TX_ACK;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            sda_oe_n  = ~sh[~bit_cnt_n];
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr + 8'd1;
            if (sda_f) state_n = WAIT_STOP;
            else       phase_n = 1'b1;
          end else if (phase && !scl_f) begin
            // ACKed: next byte goes out as soon as the ACK clock is low again.
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
            sh_n      = rd_byte;
            sda_oe_n  = ~rd_byte[7];
            state_n   = TX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
